multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle successor to the single-cycle control decoder. FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
//  Latches opcode, resolves BNE from ALU zero flag, stalls on a data-memory ready handshake, detects HALT.
//  Sits between instruction ROM / PC and datapath (reg file, ALU, data mem); drives all datapath enables.
// PARAMETERS
//  INSTR_W     9        instruction width; opcode = instr[INSTR_W-1 -: OPCODE_W]
//  OPCODE_W    3        opcode width (2**OPCODE_W opcodes)
//  ALUOP_W     3        ALUOp width
//  HALT_INSTR  9'h1FF   encoding that ends the program
//  MEM_TO      15       max MEM-state wait cycles before timeout error (0 = never)
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          async active-low reset
//  start        in   1          pulse: begin execution from current PC
//  instr        in   INSTR_W    instruction ROM output at PC (valid in FETCH)
//  alu_zero     in   1          ALU zero flag, valid in EXEC
//  mem_ready    in   1          data memory done (load data valid / store committed)
//  ir_load      out  1          latch instr into IR
//  pc_inc       out  1          PC <= PC+1
//  pc_branch    out  1          PC <= branch target (mutually exclusive with pc_inc)
//  ALUSrc       out  1          1: immediate operand, 0: reg file
//  ALUOp        out  ALUOP_W    ALU function
//  mem_req      out  1          data memory request, held until mem_ready
//  MemWrite     out  1          with mem_req: store
//  MemtoReg     out  1          WB source: 1 memory, 0 ALU
//  RegWrite     out  1          reg file write enable
//  busy         out  1          not in IDLE/HALT
//  done         out  1          HALT reached (sticky until start)
//  err          out  1          illegal opcode or MEM timeout (sticky until reset)
// BEHAVIOUR
//  Reset: state=IDLE, IR=0, wait counter=0, all outputs 0. Async assert; sync deassert assumed upstream.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//   IDLE  -start-> FETCH. HALT -start-> FETCH (done cleared same edge).
//   FETCH: ir_load=1. If instr==HALT_INSTR -> HALT (no pc_inc), else DECODE.
//   DECODE: opcode from IR; undefined ALUOp map -> err=1, HALT.
//   EXEC: ALUOp/ALUSrc driven per opcode. BNE: alu_zero=0 -> pc_branch=1, else pc_inc=1; -> FETCH.
//         LOAD/STORE -> MEM. Others -> WB.
//   MEM: mem_req=1 (MemWrite=1 for STORE). Stay until mem_ready. mem_ready: LOAD -> WB; STORE -> pc_inc=1, FETCH.
//        Counter increments each stall cycle; reaching MEM_TO (MEM_TO>0) -> err=1, HALT.
//   WB: RegWrite=1 (MemtoReg=1 for LOAD), pc_inc=1 -> FETCH.
//  Latency: ALU/MOVE/SET 4 cycles, BNE 3, STORE 4+stall, LOAD 5+stall.
//  Opcode map: 000 ADD (ALUOp 000), 001 ROR (001), 010 NAND (010), 011 LOAD, 100 STORE, 101 MOVE (111 pass-a),
//   110 BNE (SUB 011 for compare), 111 SET (ALUSrc=1, ALUOp 111). LOAD/STORE use pass-a for address.
//  Outputs are Moore: decoded from state + registered IR only; never from instr combinationally except FETCH halt test.
//  start while busy: ignored. mem_ready outside MEM: ignored. Exactly one of pc_inc/pc_branch per instruction.
//  rst_n low mid-MEM: mem_req drops immediately (async); no partial write asserted after reset.
// STRUCTURE
//  Package ctrl_pkg: state_t enum, opcode_t enum (OP_ADD..OP_SET), ALUOp localparams, HALT default.
//  Sub-module ctrl_decode (combinational opcode -> ALUOp/ALUSrc/MemWrite/MemtoReg/is_mem/is_branch/illegal);
//  top holds FSM, IR, wait counter, sticky done/err.
// TESTING
//  Reset mid-FETCH -> all outputs 0, state IDLE, busy=0 within same cycle of rst_n low.
//  start, instr=ADD (000_xxxxxx) -> ir_load, EXEC ALUOp=000, WB RegWrite=1 pc_inc=1; 4 cycles total.
//  LOAD, mem_ready after 3 stalls -> mem_req held 4 cycles, then WB MemtoReg=1 RegWrite=1; 8 cycles total.
//  BNE with alu_zero=0 -> pc_branch=1, pc_inc=0, no RegWrite; alu_zero=1 -> pc_inc=1.
//  STORE, mem_ready never, MEM_TO=15 -> err=1 after 15 stall cycles, HALT, MemWrite drops.
//  instr=9'h1FF -> done=1, busy=0, no pc_inc; second start -> done=0, FETCH next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle controller: FSM states,
// opcode map, ALU function codes and default halt encoding.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_ROR   = 3'b001,
    OP_NAND  = 3'b010,
    OP_LOAD  = 3'b011,
    OP_STORE = 3'b100,
    OP_MOVE  = 3'b101,
    OP_BNE   = 3'b110,
    OP_SET   = 3'b111
  } opcode_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_ROR   = 3'b001;
  localparam logic [2:0] ALU_NAND  = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_PASSA = 3'b111;

  localparam logic [8:0] HALT_DEFAULT   = 9'h1FF;
  localparam int         MEM_TO_DEFAULT = 15;

  // Width of the MEM wait counter; a zero or one timeout still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the latched opcode to ALU controls,
// memory direction, write-back source and instruction class.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                is_mem,
  output logic                is_branch,
  output logic                illegal
);

  logic [2:0] op_lo;
  logic       op_hi_set;
  logic [2:0] aluop3;

  assign op_lo = opcode[2:0];

  // Opcode encodings beyond the eight defined ones are illegal.
  generate
    if (OPCODE_W > 3) begin : g_wide
      assign op_hi_set = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow
      assign op_hi_set = 1'b0;
    end
  endgenerate

  always_comb begin
    aluop3     = ALU_ADD;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    is_mem     = 1'b0;
    is_branch  = 1'b0;
    illegal    = op_hi_set;
    case (opcode_t'(op_lo))
      OP_ADD:  aluop3 = ALU_ADD;
      OP_ROR:  aluop3 = ALU_ROR;
      OP_NAND: aluop3 = ALU_NAND;
      OP_LOAD: begin
        aluop3     = ALU_PASSA;
        is_mem     = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        aluop3    = ALU_PASSA;
        is_mem    = 1'b1;
        mem_write = 1'b1;
      end
      OP_MOVE: aluop3 = ALU_PASSA;
      OP_BNE: begin
        aluop3    = ALU_SUB;
        is_branch = 1'b1;
      end
      OP_SET: begin
        aluop3  = ALU_PASSA;
        alu_src = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_op = ALUOP_W'(aluop3);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// data-memory handshake, MEM timeout, HALT detection and sticky done/err.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   FETCH  | IR <= instr; halt encoding ends the program
//   DECODE | opcode latched; illegal opcode -> err, HALT
//   EXEC   | ALU controls; BNE resolves branch here
//   MEM    | mem_req held until mem_ready or timeout
//   WB     | register write, PC increment
//   HALT   | program ended; start restarts at FETCH
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int                 INSTR_W    = 9,
  parameter int                 OPCODE_W   = 3,
  parameter int                 ALUOP_W    = 3,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_DEFAULT),
  parameter int                 MEM_TO     = MEM_TO_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_branch,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mem_req,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = cnt_width(MEM_TO);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] ir_op_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q, err_q;

  logic [ALUOP_W-1:0]  dec_aluop;
  logic                dec_alusrc, dec_memwrite, dec_memtoreg;
  logic                dec_mem, dec_branch, dec_illegal;

  logic                cnt_load, cnt_dec, mem_tc, set_err;

  // Only the opcode field is held here; operand fields live in the datapath IR.
  ctrl_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .opcode    (ir_op_q),
    .alu_op    (dec_aluop),
    .alu_src   (dec_alusrc),
    .mem_write (dec_memwrite),
    .mem_to_reg(dec_memtoreg),
    .is_mem    (dec_mem),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  // Down-counter loaded on MEM entry; terminal count on the last allowed stall.
  assign mem_tc = (MEM_TO != 0) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = '0;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_load = 1'b1;
        state_d = (instr == HALT_INSTR) ? ST_HALT : ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          set_err = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALUSrc = dec_alusrc;
        ALUOp  = dec_aluop;
        if (dec_branch) begin
          pc_branch = ~alu_zero;
          pc_inc    = alu_zero;
          state_d   = ST_FETCH;
        end else if (dec_mem) begin
          cnt_load = 1'b1;
          state_d  = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // Address operands stay on the ALU for the whole access.
        ALUSrc   = dec_alusrc;
        ALUOp    = dec_aluop;
        mem_req  = 1'b1;
        MemWrite = dec_memwrite;
        if (mem_ready) begin
          if (dec_memwrite) begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (mem_tc) begin
          set_err = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = dec_memtoreg;
        pc_inc   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_op_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_op_q <= instr[INSTR_W-1 -: OPCODE_W];
      if (cnt_load)     cnt_q <= CNT_W'(MEM_TO);
      else if (cnt_dec) cnt_q <= cnt_q - CNT_W'(1);
      if (set_err) err_q <= 1'b1;
      if (state_d == ST_HALT && state_q != ST_HALT) done_q <= 1'b1;
      else if (state_q == ST_HALT && start)         done_q <= 1'b0;
    end
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected output traces built from the
// opcode rules, compared every cycle, plus literal cycle/event counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] instr = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       ir_load, pc_inc, pc_branch, ALUSrc, mem_req, MemWrite, MemtoReg, RegWrite;
  logic       busy, done, err;
  logic [2:0] ALUOp;

  multicycle_control #(.MEM_TO(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .mem_req(mem_req), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_load, pc_inc, pc_branch, alusrc;
    logic [2:0] aluop;
    logic       mem_req, memwrite, memtoreg, regwrite, busy, done, err;
  } obs_t;

  typedef struct packed {
    logic       start, zero, ready;
    logic [8:0] instr;
    obs_t       exp;
  } cyc_t;

  obs_t act, exp_q;
  assign act = {ir_load, pc_inc, pc_branch, ALUSrc, ALUOp, mem_req, MemWrite,
                MemtoReg, RegWrite, busy, done, err};

  cyc_t plan[$];
  logic chk_en = 1'b0;
  logic done_m = 1'b0, err_m = 1'b0;
  int   checks = 0, failures = 0;
  int   n_busy, n_memreq, n_pcinc, n_pcbr, n_regw, n_m2r;

  localparam logic [8:0] I_ADD   = 9'b000_000101;
  localparam logic [8:0] I_ROR   = 9'b001_000011;
  localparam logic [8:0] I_NAND  = 9'b010_110000;
  localparam logic [8:0] I_LOAD  = 9'b011_001010;
  localparam logic [8:0] I_STORE = 9'b100_010001;
  localparam logic [8:0] I_MOVE  = 9'b101_000111;
  localparam logic [8:0] I_BNE   = 9'b110_000010;
  localparam logic [8:0] I_SET   = 9'b111_000011;
  localparam logic [8:0] I_HALT  = 9'h1FF;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act !== exp_q) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%b required=%b", $time, act, exp_q);
      end
      if (act.busy)      n_busy++;
      if (act.mem_req)   n_memreq++;
      if (act.pc_inc)    n_pcinc++;
      if (act.pc_branch) n_pcbr++;
      if (act.regwrite)  n_regw++;
      if (act.memtoreg)  n_m2r++;
    end
  end

  task automatic lit(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [2:0] op);
    case (op)
      3'd0: return 3'b000;
      3'd1: return 3'b001;
      3'd2: return 3'b010;
      3'd6: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.done = done_m;
    o.err  = err_m;
    return o;
  endfunction

  task automatic push(input logic s, input logic z, input logic r,
                      input logic [8:0] i, input obs_t o);
    cyc_t c;
    c.start = s; c.zero = z; c.ready = r; c.instr = i; c.exp = o;
    plan.push_back(c);
  endtask

  // Idle/halt cycles; start pulses on the last one.
  task automatic plan_wait(input int n, input logic s);
    for (int k = 0; k < n; k++) push(s && (k == n - 1), 1'b0, 1'b1, '0, base());
    if (s) done_m = 1'b0;
  endtask

  // stalls < 0: memory never answers.
  task automatic plan_instr(input logic [8:0] ins, input logic zero, input int stalls,
                            input logic noise, input logic start_mid);
    obs_t o;
    logic [2:0] op;
    int n;
    logic rdy;
    op = ins[8:6];
    o = base(); o.ir_load = 1'b1; o.busy = 1'b1;
    push(1'b0, 1'b0, noise, ins, o);
    if (ins == I_HALT) begin done_m = 1'b1; return; end
    o = base(); o.busy = 1'b1;
    push(start_mid, 1'b0, noise, ins, o);
    o = base(); o.busy = 1'b1; o.aluop = alu_of(op); o.alusrc = (op == 3'd7);
    if (op == 3'd6) begin
      o.pc_branch = ~zero; o.pc_inc = zero;
      push(1'b0, zero, noise, ins, o);
      return;
    end
    push(1'b0, zero, noise, ins, o);
    if (op == 3'd3 || op == 3'd4) begin
      n = (stalls < 0) ? 15 : stalls + 1;
      for (int k = 0; k < n; k++) begin
        rdy = (stalls >= 0) && (k == n - 1);
        o = base(); o.busy = 1'b1; o.mem_req = 1'b1; o.memwrite = (op == 3'd4);
        o.aluop = 3'b111; o.pc_inc = rdy && (op == 3'd4);
        push(1'b0, zero, rdy, ins, o);
      end
      if (stalls < 0) begin err_m = 1'b1; done_m = 1'b1; return; end
      if (op == 3'd4) return;
    end
    o = base(); o.busy = 1'b1; o.regwrite = 1'b1; o.memtoreg = (op == 3'd3); o.pc_inc = 1'b1;
    push(1'b0, zero, noise, ins, o);
  endtask

  task automatic run_plan();
    cyc_t c;
    n_busy = 0; n_memreq = 0; n_pcinc = 0; n_pcbr = 0; n_regw = 0; n_m2r = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk); #1;
      start = c.start; alu_zero = c.zero; mem_ready = c.ready; instr = c.instr;
      exp_q = c.exp; chk_en = 1'b1;
    end
    @(posedge clk); #1;
    chk_en = 1'b0; start = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0; rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #2;
    lit("reset_outputs", int'(act), 0);
    @(negedge clk);
    rst_n = 1'b1; err_m = 1'b0; done_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ADD alone: 4 cycles + HALT fetch, start while busy ignored
    do_reset();
    plan_wait(1, 1'b1);
    plan_instr(I_ADD, 1'b0, 0, 1'b0, 1'b1);
    plan_instr(I_HALT, 1'b0, 0, 1'b0, 1'b0);
    plan_wait(1, 1'b0);
    run_plan();
    lit("add_busy_cycles", n_busy, 5);
    lit("add_regwrite", n_regw, 1);
    lit("add_pc_inc", n_pcinc, 1);

    // LOAD with 3 stalls: mem_req 4 cycles, 8 cycles total
    do_reset();
    plan_wait(1, 1'b1);
    plan_instr(I_LOAD, 1'b0, 3, 1'b0, 1'b0);
    plan_instr(I_HALT, 1'b0, 0, 1'b0, 1'b0);
    plan_wait(1, 1'b0);
    run_plan();
    lit("load_mem_req_cycles", n_memreq, 4);
    lit("load_busy_cycles", n_busy, 9);
    lit("load_memtoreg", n_m2r, 1);

    // BNE not taken / taken
    do_reset();
    plan_wait(1, 1'b1);
    plan_instr(I_BNE, 1'b0, 0, 1'b0, 1'b0);
    plan_instr(I_HALT, 1'b0, 0, 1'b0, 1'b0);
    plan_wait(1, 1'b0);
    run_plan();
    lit("bne_z0_branch", n_pcbr, 1);
    lit("bne_z0_inc", n_pcinc, 0);
    lit("bne_z0_regwrite", n_regw, 0);
    lit("bne_busy_cycles", n_busy, 4);

    // Full program mix, halt and restart
    do_reset();
    plan_wait(1, 1'b1);
    plan_instr(I_ADD, 1'b0, 0, 1'b0, 1'b1);
    plan_instr(I_ROR, 1'b0, 0, 1'b1, 1'b0);
    plan_instr(I_NAND, 1'b1, 0, 1'b0, 1'b1);
    plan_instr(I_SET, 1'b0, 0, 1'b1, 1'b0);
    plan_instr(I_MOVE, 1'b0, 0, 1'b0, 1'b0);
    plan_instr(I_BNE, 1'b0, 0, 1'b1, 1'b0);
    plan_instr(I_BNE, 1'b1, 0, 1'b0, 1'b0);
    plan_instr(I_STORE, 1'b0, 0, 1'b1, 1'b0);
    plan_instr(I_LOAD, 1'b0, 2, 1'b1, 1'b0);
    plan_instr(I_HALT, 1'b0, 0, 1'b0, 1'b0);
    plan_wait(2, 1'b1);
    plan_instr(I_ADD, 1'b0, 0, 1'b0, 1'b0);
    plan_instr(I_HALT, 1'b0, 0, 1'b0, 1'b0);
    plan_wait(1, 1'b0);
    run_plan();
    lit("prog_pc_inc", n_pcinc, 9);
    lit("prog_pc_branch", n_pcbr, 1);
    lit("prog_regwrite", n_regw, 7);
    lit("prog_done", int'(done), 1);

    // STORE with no memory answer: timeout after 15 stalls
    do_reset();
    plan_wait(1, 1'b1);
    plan_instr(I_STORE, 1'b0, -1, 1'b0, 1'b0);
    plan_wait(2, 1'b0);
    run_plan();
    lit("timeout_mem_req_cycles", n_memreq, 15);
    lit("timeout_busy_cycles", n_busy, 18);
    lit("timeout_err", int'(err), 1);
    lit("timeout_memwrite", int'(MemWrite), 0);
    do_reset();
    lit("err_cleared_by_reset", int'(err), 0);

    // Reset asserted during FETCH
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; instr = I_ADD;
    #1;
    lit("fetch_ir_load", int'(ir_load), 1);
    rst_n = 1'b0;
    #1;
    lit("fetch_reset_outputs", int'(act), 0);
    lit("fetch_reset_busy", int'(busy), 0);
    do_reset();

    // Reset asserted during a STORE's MEM access
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; instr = I_STORE;
    repeat (3) @(posedge clk);
    #3;
    lit("mem_req_before_reset", int'(mem_req), 1);
    lit("memwrite_before_reset", int'(MemWrite), 1);
    rst_n = 1'b0;
    #1;
    lit("mem_req_after_reset", int'(mem_req), 0);
    lit("memwrite_after_reset", int'(MemWrite), 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
